// File: rtl/servant_spi_fram_ctrl.sv
// Wishbone slave serving servant's memory port from an SPI FRAM (mode 0).
// Reads issue READ; writes issue WREN, a short CS_n-high gap, then WRITE.
module servant_spi_fram_ctrl #(
    parameter int ADDR_BITS = 18,
    parameter int CLK_DIV   = 2
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic [ADDR_BITS-3:0] i_wb_adr,
    input  logic [31:0]          i_wb_dat,
    input  logic [3:0]           i_wb_sel,
    input  logic                 i_wb_we,
    input  logic                 i_wb_cyc,
    output logic [31:0]          o_wb_rdt,
    output logic                 o_wb_ack,
    output logic                 o_sclk,
    output logic                 o_cs_n,
    output logic                 o_mosi,
    input  logic                 i_miso
);

    typedef enum logic [2:0] {IDLE, WREN, GAP, CMD, ADDR, DATA, DONE} state_t;

    localparam int              DW         = $clog2(2 * CLK_DIV);
    localparam logic [DW-1:0]   RISE       = DW'(CLK_DIV - 1);
    localparam logic [DW-1:0]   LAST       = DW'(2 * CLK_DIV - 1);
    localparam logic [63:0]     WREN_FRAME = {8'h06, 56'h0};

    state_t               state_q, state_d;
    logic [ADDR_BITS-3:0] adr_q, adr_d;
    logic [31:0]          dat_q, dat_d;
    logic [3:0]           sel_q, sel_d;
    logic                 we_q, we_d;
    logic [31:0]          rdt_q, rdt_d;
    logic [31:0]          rx_q, rx_d;
    logic [63:0]          tx_q, tx_d;
    logic [DW-1:0]        div_q, div_d;
    logic [5:0]           bit_q, bit_d;
    logic                 cs_n_q, cs_n_d;
    logic                 sclk_q, sclk_d;
    logic                 mosi_q, mosi_d;
    logic                 ack_q, ack_d;

    logic [1:0]           lo_idx, hi_idx, span;
    logic [5:0]           data_bits, phase_len;
    logic [31:0]          wr_word;
    logic [63:0]          rd_frame, wr_frame;

    function automatic logic [31:0] byterev(input logic [31:0] w);
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
    endfunction

    // Writes address the first enabled byte and stream only the enabled span.
    always_comb begin
        lo_idx = 2'd0;
        hi_idx = 2'd0;
        for (int unsigned i = 0; i < 4; i++) begin
            if (sel_q[3 - i]) lo_idx = 2'(3 - i);
            if (sel_q[i])     hi_idx = 2'(i);
        end
        span      = hi_idx - lo_idx;
        data_bits = ({4'b0, span} + 6'd1) << 3;
        wr_word   = byterev(dat_q >> {lo_idx, 3'b000});
        wr_frame  = {8'h02, 24'({adr_q, lo_idx}), wr_word};
        rd_frame  = {8'h03, 24'({i_wb_adr, 2'b00}), 32'h0};
        case (state_q)
            ADDR:    phase_len = 6'd24;
            DATA:    phase_len = we_q ? data_bits : 6'd32;
            default: phase_len = 6'd8;
        endcase
    end

    always_comb begin
        state_d = state_q;
        adr_d   = adr_q;
        dat_d   = dat_q;
        sel_d   = sel_q;
        we_d    = we_q;
        rdt_d   = rdt_q;
        rx_d    = rx_q;
        tx_d    = tx_q;
        div_d   = div_q;
        bit_d   = bit_q;
        cs_n_d  = cs_n_q;
        sclk_d  = sclk_q;
        mosi_d  = mosi_q;

        case (state_q)
            IDLE: begin
                if (i_wb_cyc) begin
                    adr_d  = i_wb_adr;
                    dat_d  = i_wb_dat;
                    sel_d  = i_wb_sel;
                    we_d   = i_wb_we;
                    div_d  = '0;
                    bit_d  = '0;
                    sclk_d = 1'b0;
                    if (i_wb_we && i_wb_sel == 4'b0000) begin
                        state_d = DONE;
                    end else if (i_wb_we) begin
                        state_d = WREN;
                        cs_n_d  = 1'b0;
                        mosi_d  = WREN_FRAME[63];
                        tx_d    = WREN_FRAME << 1;
                    end else begin
                        state_d = CMD;
                        cs_n_d  = 1'b0;
                        mosi_d  = rd_frame[63];
                        tx_d    = rd_frame << 1;
                    end
                end
            end
            WREN, CMD, ADDR, DATA: begin
                // CS_n already high in DATA marks the one idle cycle before ack.
                if (state_q == DATA && cs_n_q) begin
                    state_d = DONE;
                end else begin
                    div_d = div_q + 1'b1;
                    if (div_q == RISE) begin
                        sclk_d = 1'b1;
                        if (state_q == DATA && !we_q) begin
                            rx_d = {rx_q[30:0], i_miso};
                            if (bit_q == 6'd31) rdt_d = byterev(rx_d);
                        end
                    end
                    if (div_q == LAST) begin
                        sclk_d = 1'b0;
                        div_d  = '0;
                        mosi_d = tx_q[63];
                        tx_d   = tx_q << 1;
                        bit_d  = bit_q + 6'd1;
                        if (bit_q == phase_len - 6'd1) begin
                            bit_d = '0;
                            case (state_q)
                                WREN: begin
                                    state_d = GAP;
                                    cs_n_d  = 1'b1;
                                    mosi_d  = 1'b0;
                                end
                                CMD:  state_d = ADDR;
                                ADDR: state_d = DATA;
                                default: begin
                                    cs_n_d = 1'b1;
                                    mosi_d = 1'b0;
                                end
                            endcase
                        end
                    end
                end
            end
            GAP: begin
                div_d = div_q + 1'b1;
                if (div_q == LAST) begin
                    state_d = CMD;
                    div_d   = '0;
                    bit_d   = '0;
                    cs_n_d  = 1'b0;
                    mosi_d  = wr_frame[63];
                    tx_d    = wr_frame << 1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        ack_d = (state_d == DONE);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= IDLE;
            adr_q   <= '0;
            dat_q   <= '0;
            sel_q   <= '0;
            we_q    <= 1'b0;
            rdt_q   <= '0;
            rx_q    <= '0;
            tx_q    <= '0;
            div_q   <= '0;
            bit_q   <= '0;
            cs_n_q  <= 1'b1;
            sclk_q  <= 1'b0;
            mosi_q  <= 1'b0;
            ack_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            adr_q   <= adr_d;
            dat_q   <= dat_d;
            sel_q   <= sel_d;
            we_q    <= we_d;
            rdt_q   <= rdt_d;
            rx_q    <= rx_d;
            tx_q    <= tx_d;
            div_q   <= div_d;
            bit_q   <= bit_d;
            cs_n_q  <= cs_n_d;
            sclk_q  <= sclk_d;
            mosi_q  <= mosi_d;
            ack_q   <= ack_d;
        end
    end

    assign o_wb_rdt = rdt_q;
    assign o_wb_ack = ack_q;
    assign o_sclk   = sclk_q;
    assign o_cs_n   = cs_n_q;
    assign o_mosi   = mosi_q;

endmodule

// File: tb/tb_servant_spi_fram_ctrl.sv
// Scoreboard bench: a byte-addressed FRAM model checks SPI frames, a monitor
// checks every ack against queued expected latency and read data.
module tb_servant_spi_fram_ctrl;
    localparam int ADDR_BITS = 18;
    localparam int CLK_DIV   = 2;
    localparam int CLKP      = 10;

    logic                 i_clk = 1'b0;
    logic                 i_rst;
    logic [ADDR_BITS-3:0] i_wb_adr;
    logic [31:0]          i_wb_dat;
    logic [3:0]           i_wb_sel;
    logic                 i_wb_we;
    logic                 i_wb_cyc;
    logic [31:0]          o_wb_rdt;
    logic                 o_wb_ack;
    logic                 o_sclk;
    logic                 o_cs_n;
    logic                 o_mosi;
    logic                 i_miso;

    servant_spi_fram_ctrl #(.ADDR_BITS(ADDR_BITS), .CLK_DIV(CLK_DIV)) dut (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .i_wb_adr (i_wb_adr),
        .i_wb_dat (i_wb_dat),
        .i_wb_sel (i_wb_sel),
        .i_wb_we  (i_wb_we),
        .i_wb_cyc (i_wb_cyc),
        .o_wb_rdt (o_wb_rdt),
        .o_wb_ack (o_wb_ack),
        .o_sclk   (o_sclk),
        .o_cs_n   (o_cs_n),
        .o_mosi   (o_mosi),
        .i_miso   (i_miso)
    );

    always #(CLKP / 2) i_clk = ~i_clk;

    typedef struct {
        logic [31:0] rdt;
        bit          chk_rdt;
        int          lat;
        int          t0;
        string       name;
    } txn_t;

    typedef struct {
        logic [63:0] bits;
        int          n;
        int          gap;
        string       name;
    } frame_t;

    int   tests_run = 0;
    int   fails     = 0;
    int   ccount    = 0;
    int   acks      = 0;
    int   frames    = 0;
    int   cs_falls  = 0;
    txn_t   sb_q[$];
    frame_t fr_q[$];
    logic [7:0] mem [0:1023];

    always @(posedge i_clk) ccount <= ccount + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests_run++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic expect_frame(input logic [63:0] bits, input int n, input int gap, input string name);
        frame_t f;
        f.bits = bits;
        f.n    = n;
        f.gap  = gap;
        f.name = name;
        fr_q.push_back(f);
    endtask

    // Ack monitor: pops the scoreboard on every ack pulse.
    always @(negedge i_clk) begin : mon
        txn_t t;
        if (i_rst === 1'b0 && o_wb_ack === 1'b1) begin
            acks++;
            chk("ack_expected", 64'(sb_q.size() != 0), 64'd1);
            if (sb_q.size() != 0) begin
                t = sb_q.pop_front();
                chk({t.name, "_latency"}, 64'(ccount - t.t0), 64'(t.lat));
                if (t.chk_rdt) chk({t.name, "_rdt"}, 64'(o_wb_rdt), 64'(t.rdt));
            end
        end
    end

    // FRAM model: samples MOSI on SCLK rise, updates MISO just after it.
    initial begin : fram
        logic [63:0] cap;
        int          n;
        logic [7:0]  cmd;
        logic [23:0] fa;
        logic [7:0]  bytev;
        bit          wel;
        time         last_rise;
        int          gap;
        frame_t      e;
        i_miso    = 1'b0;
        wel       = 1'b0;
        last_rise = 0;
        forever begin
            @(negedge o_cs_n);
            cs_falls++;
            gap = int'(($time - last_rise) / CLKP);
            cap = '0;
            n   = 0;
            cmd = '0;
            fa  = '0;
            forever begin
                @(posedge o_sclk or posedge o_cs_n);
                if (o_cs_n !== 1'b0) break;
                cap = {cap[62:0], o_mosi};
                n++;
                if (n == 8)  cmd = cap[7:0];
                if (n == 32) fa  = cap[23:0];
                if (cmd == 8'h03 && n >= 32 && n < 64) begin
                    bytev  = mem[(int'(fa[9:0]) + (n - 32) / 8) % 1024];
                    i_miso = bytev[7 - (n - 32) % 8];
                end
                if (cmd == 8'h02 && wel && n > 32 && (n - 32) % 8 == 0)
                    mem[(int'(fa[9:0]) + (n - 32) / 8 - 1) % 1024] = cap[7:0];
            end
            i_miso    = 1'b0;
            last_rise = $time;
            frames++;
            if (n == 8 && cap[7:0] == 8'h06) wel = 1'b1;
            else if (cmd == 8'h02) wel = 1'b0;
            chk("frame_expected", 64'(fr_q.size() != 0), 64'd1);
            if (fr_q.size() != 0) begin
                e = fr_q.pop_front();
                if (e.n >= 0) begin
                    chk({e.name, "_bits"}, 64'(n), 64'(e.n));
                    chk({e.name, "_data"}, cap, e.bits);
                end
                if (e.gap >= 0) chk({e.name, "_gap"}, 64'(gap), 64'(e.gap));
            end
        end
    end

    task automatic issue(input bit we, input logic [ADDR_BITS-3:0] adr, input logic [31:0] dat,
                         input logic [3:0] sel, input logic [31:0] exp_rdt, input bit chk_rdt,
                         input int lat, input string name, input bit drop_cyc);
        txn_t t;
        bit   seen;
        @(negedge i_clk);
        i_wb_we  = we;
        i_wb_adr = adr;
        i_wb_dat = dat;
        i_wb_sel = sel;
        i_wb_cyc = 1'b1;
        t.rdt     = exp_rdt;
        t.chk_rdt = chk_rdt;
        t.lat     = lat;
        t.t0      = ccount;
        t.name    = name;
        sb_q.push_back(t);
        if (drop_cyc) begin
            @(negedge i_clk);
            i_wb_cyc = 1'b0;
        end
        seen = 1'b0;
        for (int i = 0; i < 2000 && !seen; i++) begin
            @(negedge i_clk);
            if (o_wb_ack === 1'b1) seen = 1'b1;
        end
        chk({name, "_ack_seen"}, 64'(seen), 64'd1);
        i_wb_cyc = 1'b0;
        @(negedge i_clk);
    endtask

    task automatic chk_idle(input string name);
        chk({name, "_cs_n"}, 64'(o_cs_n), 64'd1);
        chk({name, "_sclk"}, 64'(o_sclk), 64'd0);
        chk({name, "_mosi"}, 64'(o_mosi), 64'd0);
        chk({name, "_ack"},  64'(o_wb_ack), 64'd0);
        chk({name, "_rdt"},  64'(o_wb_rdt), 64'd0);
    endtask

    initial begin : watchdog
        #(CLKP * 100000);
        fails++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        int f0;
        int a0;
        i_rst    = 1'b1;
        i_wb_cyc = 1'b0;
        i_wb_we  = 1'b0;
        i_wb_adr = '0;
        i_wb_dat = '0;
        i_wb_sel = '0;
        for (int i = 0; i < 1024; i++) mem[i] = 8'h00;
        mem[256] = 8'h11;
        mem[257] = 8'h22;
        mem[258] = 8'h33;
        mem[259] = 8'h44;
        repeat (3) @(negedge i_clk);
        chk_idle("reset");
        i_rst = 1'b0;

        expect_frame(64'h0300010000000000, 64, -1, "rd40");
        issue(1'b0, 16'h0040, 32'h0, 4'hF, 32'h44332211, 1'b1, 258, "rd40", 1'b0);

        expect_frame(64'h06, 8, -1, "sw_wren");
        expect_frame(64'h02000104EFBEADDE, 64, 4, "sw_write");
        issue(1'b1, 16'h0041, 32'hDEADBEEF, 4'hF, 32'h0, 1'b0, 294, "sw", 1'b0);

        expect_frame(64'h0300010400000000, 64, -1, "rd41_sw");
        issue(1'b0, 16'h0041, 32'h0, 4'hF, 32'hDEADBEEF, 1'b1, 258, "rd41_sw", 1'b0);

        expect_frame(64'h06, 8, -1, "sb_wren");
        expect_frame(64'h02000106AB, 40, 4, "sb_write");
        issue(1'b1, 16'h0041, 32'h00AB0000, 4'b0100, 32'h0, 1'b0, 198, "sb", 1'b0);

        expect_frame(64'h0300010400000000, 64, -1, "rd41_sb");
        issue(1'b0, 16'h0041, 32'h0, 4'hF, 32'hDEABBEEF, 1'b1, 258, "rd41_sb", 1'b0);

        f0 = cs_falls;
        issue(1'b1, 16'h0041, 32'h55555555, 4'b0000, 32'h0, 1'b0, 1, "sel0", 1'b0);
        chk("sel0_no_cs", 64'(cs_falls), 64'(f0));

        // Write aborted by reset in its address phase: no ack, memory untouched.
        expect_frame(64'h06, 8, -1, "rst_wren");
        expect_frame(64'h0, -1, -1, "rst_partial");
        @(negedge i_clk);
        i_wb_we  = 1'b1;
        i_wb_adr = 16'h0041;
        i_wb_dat = 32'h12345678;
        i_wb_sel = 4'hF;
        i_wb_cyc = 1'b1;
        repeat (80) @(negedge i_clk);
        i_rst = 1'b1;
        @(negedge i_clk);
        chk_idle("midreset");
        i_wb_cyc = 1'b0;
        i_rst    = 1'b0;
        repeat (4) @(negedge i_clk);

        expect_frame(64'h0300010400000000, 64, -1, "rd41_rst");
        issue(1'b0, 16'h0041, 32'h0, 4'hF, 32'hDEABBEEF, 1'b1, 258, "rd41_rst", 1'b0);

        expect_frame(64'h0300010000000000, 64, -1, "rd_drop");
        issue(1'b0, 16'h0040, 32'h0, 4'hF, 32'h44332211, 1'b1, 258, "rd_drop", 1'b1);
        a0 = acks;
        f0 = frames;
        repeat (300) @(negedge i_clk);
        chk("drop_single_ack", 64'(acks), 64'(a0));
        chk("drop_single_frame", 64'(frames), 64'(f0));

        chk("scoreboard_drained", 64'(sb_q.size()), 64'd0);
        chk("frames_drained", 64'(fr_q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

endmodule
